// File: rtl/pe_tail_pkg.sv
// Shared definitions for the systolic-array tail stage.
//   V_E_F_Bit : width of the V/E/F score datapath
//   my_max    : unsigned two-input maximum, shared comparator
package pe_tail_pkg;

   localparam int V_E_F_Bit = 16;

   // One FIFO entry is {t, v, f}.
   localparam int ENTRY_W = 2 + 2 * V_E_F_Bit;

   function automatic logic [V_E_F_Bit-1:0] my_max(input logic [V_E_F_Bit-1:0] a,
                                                   input logic [V_E_F_Bit-1:0] b);
      return (b > a) ? b : a;
   endfunction

endpackage

// File: rtl/pe_tail_fifo.sv
// Boundary-column FIFO (module sync_fifo).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, wdata       write request and entry
//   pop_req           read request; ignored while empty
//   rdata, rd_valid   registered popped entry and one-cycle valid pulse
//   empty, full,count registered occupancy status
//   overflow          sticky; a push was dropped while full with no pop
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 34
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop_req,
   output logic [WIDTH-1:0]           rdata,
   output logic                       rd_valid,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             rd_valid_q, rd_valid_d;
   logic             overflow_q, overflow_d;

   logic is_empty, is_full, do_pop, do_push;

   always_comb begin
      is_empty = (count_q == '0);
      is_full  = (count_q == FULL_CNT);
      do_pop   = pop_req && !is_empty;
      // A pop in the same cycle frees a slot, so a full FIFO still accepts.
      do_push  = push && (!is_full || do_pop);

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rdata_d    = rdata_q;
      rd_valid_d = do_pop;
      overflow_d = overflow_q || (push && !do_push);

      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         rdata_d  = mem_q[rd_ptr_q];
      end
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rdata_q    <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rdata_q    <= rdata_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is never read before it is written, so it carries no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata    = rdata_q;
   assign rd_valid = rd_valid_q;
   assign empty    = is_empty;
   assign full     = is_full;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/pe_tail.sv
// Tail of the systolic array: tracks the row/column of each cell leaving the
// last PE, keeps the best score and its position, and buffers the boundary
// column {t, V, F} in a FIFO for the array feeder.
// Ports:
//   clk, rst                     clock, async active-low reset
//   validIn, newLineIn           cell strobe, first-cell-of-row flag
//   tIn, vIn, fIn                cell symbol / score / F value
//   clearMax                     restart max and position tracking
//   rdReq                        pop request
//   rdV, rdF, rdT, rdValid       popped entry and its valid pulse
//   empty, full, count, overflow FIFO status
//   maxScore, maxRow, maxCol     best score and its position
module pe_tail
   import pe_tail_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int POS_BIT = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    validIn,
   input  logic                    newLineIn,
   input  logic [1:0]              tIn,
   input  logic [V_E_F_Bit-1:0]    vIn,
   input  logic [V_E_F_Bit-1:0]    fIn,
   input  logic                    clearMax,
   input  logic                    rdReq,
   output logic [V_E_F_Bit-1:0]    rdV,
   output logic [V_E_F_Bit-1:0]    rdF,
   output logic [1:0]              rdT,
   output logic                    rdValid,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count,
   output logic [V_E_F_Bit-1:0]    maxScore,
   output logic [POS_BIT-1:0]      maxRow,
   output logic [POS_BIT-1:0]      maxCol,
   output logic                    overflow
);

   logic                  started_q, started_d;
   logic [POS_BIT-1:0]    cur_row_q, cur_row_d;
   logic [POS_BIT-1:0]    cur_col_q, cur_col_d;
   logic [V_E_F_Bit-1:0]  max_score_q, max_score_d;
   logic [POS_BIT-1:0]    max_row_q, max_row_d;
   logic [POS_BIT-1:0]    max_col_q, max_col_d;

   // Tracking state after an optional clear; a cell arriving with clearMax
   // is judged against this cleared view.
   logic                  base_started;
   logic [POS_BIT-1:0]    base_row, base_col, base_max_row, base_max_col;
   logic [V_E_F_Bit-1:0]  base_max;
   logic [POS_BIT-1:0]    cell_row, cell_col;

   always_comb begin
      base_started = started_q;
      base_row     = cur_row_q;
      base_col     = cur_col_q;
      base_max     = max_score_q;
      base_max_row = max_row_q;
      base_max_col = max_col_q;
      if (clearMax) begin
         base_started = 1'b0;
         base_row     = '0;
         base_col     = '0;
         base_max     = '0;
         base_max_row = '0;
         base_max_col = '0;
      end

      if (!base_started) begin
         cell_row = '0;
         cell_col = '0;
      end else if (newLineIn) begin
         cell_row = base_row + POS_BIT'(1);
         cell_col = '0;
      end else begin
         cell_row = base_row;
         cell_col = base_col + POS_BIT'(1);
      end

      started_d   = base_started;
      cur_row_d   = base_row;
      cur_col_d   = base_col;
      max_score_d = base_max;
      max_row_d   = base_max_row;
      max_col_d   = base_max_col;

      if (validIn) begin
         started_d = 1'b1;
         cur_row_d = cell_row;
         cur_col_d = cell_col;
         // Strictly greater: a tie keeps the earlier position.
         if (vIn > base_max) begin
            max_score_d = my_max(base_max, vIn);
            max_row_d   = cell_row;
            max_col_d   = cell_col;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         started_q   <= 1'b0;
         cur_row_q   <= '0;
         cur_col_q   <= '0;
         max_score_q <= '0;
         max_row_q   <= '0;
         max_col_q   <= '0;
      end else begin
         started_q   <= started_d;
         cur_row_q   <= cur_row_d;
         cur_col_q   <= cur_col_d;
         max_score_q <= max_score_d;
         max_row_q   <= max_row_d;
         max_col_q   <= max_col_d;
      end
   end

   logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

   assign fifo_wdata = {tIn, vIn, fIn};

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst),
      .push     (validIn),
      .wdata    (fifo_wdata),
      .pop_req  (rdReq),
      .rdata    (fifo_rdata),
      .rd_valid (rdValid),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow)
   );

   assign rdT      = fifo_rdata[ENTRY_W-1 -: 2];
   assign rdV      = fifo_rdata[2*V_E_F_Bit-1 -: V_E_F_Bit];
   assign rdF      = fifo_rdata[V_E_F_Bit-1:0];
   assign maxScore = max_score_q;
   assign maxRow   = max_row_q;
   assign maxCol   = max_col_q;

endmodule

// File: doc/pe_tail.md
PE_TAIL -- requirements
Module: pe_tail

Interface
REQ-001 Parameter DEPTH, default 16, boundary-column FIFO depth; power of two, at least 2.
REQ-002 Parameter POS_BIT, default 10, width of the row and column position counters.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 validIn  input  1  last-PE outputs carry a valid cell this cycle.
REQ-006 newLineIn  input  1  the cell is the first cell of a new row (last PE newLineOut).
REQ-007 tIn  input  2  symbol from last PE; passed through to FIFO side-band.
REQ-008 vIn  input  V_E_F_Bit  cell score V, non-negative, compared unsigned.
REQ-009 fIn  input  V_E_F_Bit  cell F value.
REQ-010 clearMax  input  1  synchronous restart of max and position tracking.
REQ-011 rdReq  input  1  pop request from the array feeder.
REQ-012 rdV, rdF  output  V_E_F_Bit each  popped boundary V and F.
REQ-013 rdT  output  2  popped symbol.
REQ-014 rdValid  output  1  one-cycle pulse; rdV/rdF/rdT are valid.
REQ-015 empty, full  output  1 each  FIFO status.
REQ-016 count  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-017 maxScore  output  V_E_F_Bit  best V since the last clear or reset.
REQ-018 maxRow, maxCol  output  POS_BIT each  position of maxScore.
REQ-019 overflow  output  1  sticky; a push was dropped.

Function
REQ-020 A cycle with validIn=1 SHALL compute a cell position: not started -> (0,0); newLineIn -> (curRow+1, 0); otherwise (curRow, curCol+1).
REQ-021 The cycle after any valid cell, started SHALL be 1 and curRow/curCol SHALL hold the cell position.
REQ-022 Counters SHALL wrap modulo 2^POS_BIT with no flag.
REQ-023 If vIn > maxScore (strictly greater), the next cycle SHALL load maxScore=vIn, maxRow/maxCol = cell position. Ties SHALL keep the earlier cell.
REQ-024 clearMax=1 SHALL clear maxScore, maxRow, maxCol, curRow, curCol and started. A valid cell in the same cycle SHALL then be evaluated against the cleared state: position (0,0), compared with 0.
REQ-025 A valid cell SHALL push {tIn, vIn, fIn} into the FIFO. If the FIFO is full and no pop occurs in the same cycle, the push SHALL be dropped and overflow SHALL be set.
REQ-026 rdReq with empty=0 SHALL pop the FIFO head. rdV/rdF/rdT SHALL be registered and rdValid=1 on the next cycle; otherwise rdValid=0 and the rd data holds.
REQ-027 rdReq while empty SHALL be ignored: no pop, no rdValid, no error.
REQ-028 Simultaneous push and pop when full SHALL both succeed; count is unchanged.
REQ-029 Simultaneous push and pop when empty SHALL perform the push only; rdValid=0.
REQ-030 A pushed entry SHALL become poppable the cycle after the push. empty/full/count SHALL be registered and reflect the state after the edge.
REQ-031 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap naturally.
REQ-032 overflow SHALL clear only on reset.

Reset
REQ-033 While rst=0, all outputs SHALL be 0 except empty=1.
REQ-034 While rst=0, internal pointers, counters and started SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL discard FIFO contents and max state immediately, without waiting for a clock edge.
REQ-036 FIFO storage array SHALL NOT require reset; its contents are unobservable until written.

Structure
REQ-037 V_E_F_Bit SHALL come from the shared util.v header.
REQ-038 The shared myMax comparator SHALL be reused where convenient.
REQ-039 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by DEPTH and WIDTH (2+2*V_E_F_Bit).
REQ-040 Position and max logic SHALL stay in pe_tail.

Verification
REQ-041 Reset check: pulse rst low mid-stream -> immediately maxScore=0, count=0, empty=1, overflow=0, rdValid=0.
REQ-042 Max tracking: cells V=3,7,7,2 in row 0, then newLine V=9 -> maxScore=7 at (0,1), then 9 at (1,0).
REQ-043 Overflow: DEPTH=16, push 17 cells with no reads -> full=1, count=16, overflow=1; 16 pops return the first 16 cells in order.
REQ-044 Full with simultaneous push/pop: FIFO full, push and pop together -> count stays 16, rdValid=1 next cycle with the oldest entry, overflow stays 0.
REQ-045 Empty edge: rdReq while empty -> no rdValid; push and rdReq in the same cycle when empty -> count=1, rdValid=0; rdReq next cycle -> rdValid=1 with that entry.
REQ-046 Clear collision: clearMax with a valid cell V=5 after maxScore=20 -> maxScore=5, position (0,0).
